// File: rtl/awgn_sequencer.sv
// Sequences one Box-Muller pair: fetches a uniform pair, drives the external log,
// sqrt and sin/cos units, multiplies the results and emits two Q5.11 samples.
module awgn_sequencer #(
  parameter int unsigned LOG_LAT  = 1,
  parameter int unsigned SQRT_LAT = 1,
  parameter int unsigned SC_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        urng_valid,
  output logic        urng_ready,
  input  logic [47:0] urng_u0,
  input  logic [15:0] urng_u1,
  output logic [47:0] log_u0,
  input  logic [30:0] log_e,
  output logic [30:0] sqrt_e,
  input  logic [16:0] sqrt_f,
  output logic [15:0] sc_u1,
  input  logic [15:0] sc_g0,
  input  logic [15:0] sc_g1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] pair_cnt
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOG   = 3'd2,
    SQRT  = 3'd3,
    MUL   = 3'd4,
    OUT0  = 3'd5,
    OUT1  = 3'd6
  } state_e;

  // sin/cos results are sampled at the end of SQRT, so SC_LAT must fit in LOG+SQRT time
  if (LOG_LAT < 1 || LOG_LAT > 15 || SQRT_LAT < 1 || SQRT_LAT > 15 ||
      SC_LAT < 1 || SC_LAT > LOG_LAT + SQRT_LAT) begin : g_param_check
    $error("awgn_sequencer: latency parameter out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             urng_ready_q, urng_ready_d;
  logic [47:0]      log_u0_q, log_u0_d;
  logic [15:0]      sc_u1_q, sc_u1_d;
  logic [30:0]      sqrt_e_q, sqrt_e_d;
  logic [16:0]      f_q, f_d;
  logic [15:0]      g0_q, g0_d;
  logic [15:0]      g1_q, g1_d;
  logic [15:0]      x1_q, x1_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic [15:0]      pair_cnt_q, pair_cnt_d;
  logic [33:0]      x0_c, x1_c;

  // f zero-extended, g sign-extended; low 34 bits are the same for signed/unsigned multiply
  assign x0_c = 34'(f_q) * 34'($signed(g0_q));
  assign x1_c = 34'(f_q) * 34'($signed(g1_q));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    log_u0_d   = log_u0_q;
    sc_u1_d    = sc_u1_q;
    sqrt_e_d   = sqrt_e_q;
    f_d        = f_q;
    g0_d       = g0_q;
    g1_d       = g1_q;
    x1_d       = x1_q;
    out_data_d = out_data_q;
    pair_cnt_d = pair_cnt_q;

    case (state_q)
      IDLE: if (en) state_d = FETCH;
      FETCH: begin
        if (urng_valid) begin
          log_u0_d = (urng_u0 == 48'd0) ? 48'd1 : urng_u0;
          sc_u1_d  = urng_u1;
          cnt_d    = '0;
          state_d  = LOG;
        end
      end
      LOG: begin
        if (cnt_q == CNT_W'(LOG_LAT - 1)) begin
          sqrt_e_d = log_e;
          cnt_d    = '0;
          state_d  = SQRT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SQRT: begin
        if (cnt_q == CNT_W'(SQRT_LAT - 1)) begin
          f_d     = sqrt_f;
          g0_d    = sc_g0;
          g1_d    = sc_g1;
          cnt_d   = '0;
          state_d = MUL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MUL: begin
        out_data_d = 16'(x0_c >> 17);
        x1_d       = 16'(x1_c >> 17);
        state_d    = OUT0;
      end
      OUT0: begin
        if (out_ready) begin
          out_data_d = x1_q;
          state_d    = OUT1;
        end
      end
      OUT1: begin
        if (out_ready) begin
          pair_cnt_d = pair_cnt_q + 16'd1;
          state_d    = en ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    urng_ready_d = (state_d == FETCH);
    out_valid_d  = (state_d == OUT0) || (state_d == OUT1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      urng_ready_q <= 1'b0;
      log_u0_q     <= '0;
      sc_u1_q      <= '0;
      sqrt_e_q     <= '0;
      f_q          <= '0;
      g0_q         <= '0;
      g1_q         <= '0;
      x1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      pair_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      urng_ready_q <= urng_ready_d;
      log_u0_q     <= log_u0_d;
      sc_u1_q      <= sc_u1_d;
      sqrt_e_q     <= sqrt_e_d;
      f_q          <= f_d;
      g0_q         <= g0_d;
      g1_q         <= g1_d;
      x1_q         <= x1_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      pair_cnt_q   <= pair_cnt_d;
    end
  end

  assign urng_ready = urng_ready_q;
  assign log_u0     = log_u0_q;
  assign sqrt_e     = sqrt_e_q;
  assign sc_u1      = sc_u1_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pair_cnt   = pair_cnt_q;

endmodule

// File: tb/tb_awgn_sequencer.sv
// Bench for awgn_sequencer: vector table, hand sequences and a random run scored
// against a Box-Muller pair model with mock log/sqrt/sin-cos units.
module tb_awgn_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, en, urng_valid, out_ready;
  logic [47:0] urng_u0;
  logic [15:0] urng_u1;

  logic        urng_ready, out_valid;
  logic [47:0] log_u0;
  logic [30:0] log_e, sqrt_e;
  logic [16:0] sqrt_f;
  logic [15:0] sc_u1, sc_g0, sc_g1, out_data, pair_cnt;

  logic        urng_ready2, out_valid2;
  logic [47:0] log_u0_2;
  logic [30:0] log_e2, sqrt_e_2;
  logic [16:0] sqrt_f2;
  logic [15:0] sc_u1_2, sc_g0_2, sc_g1_2, out_data2, pair_cnt2;

  logic        use_fix;
  logic [16:0] fx_f;
  logic [15:0] fx_g0, fx_g1;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  awgn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .urng_valid(urng_valid), .urng_ready(urng_ready),
    .urng_u0(urng_u0), .urng_u1(urng_u1), .log_u0(log_u0), .log_e(log_e),
    .sqrt_e(sqrt_e), .sqrt_f(sqrt_f), .sc_u1(sc_u1), .sc_g0(sc_g0), .sc_g1(sc_g1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .pair_cnt(pair_cnt)
  );

  awgn_sequencer #(.LOG_LAT(3), .SQRT_LAT(2), .SC_LAT(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .urng_valid(urng_valid), .urng_ready(urng_ready2),
    .urng_u0(urng_u0), .urng_u1(urng_u1), .log_u0(log_u0_2), .log_e(log_e2),
    .sqrt_e(sqrt_e_2), .sqrt_f(sqrt_f2), .sc_u1(sc_u1_2), .sc_g0(sc_g0_2), .sc_g1(sc_g1_2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .pair_cnt(pair_cnt2)
  );

  // Mock arithmetic units: arbitrary but deterministic functions of their operands
  function automatic logic [30:0] m_log(input logic [47:0] u);
    return 31'(u ^ (u >> 23));
  endfunction
  function automatic logic [16:0] m_sqrt(input logic [30:0] e);
    return 17'(e ^ (e >> 11));
  endfunction
  function automatic logic [15:0] m_g0(input logic [15:0] u);
    return 16'(u * 16'd40503);
  endfunction
  function automatic logic [15:0] m_g1(input logic [15:0] u);
    return {u[7:0], u[15:8]} ^ 16'h5A5A;
  endfunction

  // Default-latency unit: results valid one cycle after the operand settles
  assign log_e  = m_log(log_u0);
  assign sqrt_f = use_fix ? fx_f  : m_sqrt(sqrt_e);
  assign sc_g0  = use_fix ? fx_g0 : m_g0(sc_u1);
  assign sc_g1  = use_fix ? fx_g1 : m_g1(sc_u1);

  // Slow units for dut2: results appear only LAT cycles after the operand changes
  logic [47:0] lp2_q [1:2];
  logic [30:0] sp2_q;
  logic [15:0] cp2_q [1:4];
  always @(posedge clk) begin
    lp2_q[1] <= log_u0_2;
    lp2_q[2] <= lp2_q[1];
    sp2_q    <= sqrt_e_2;
    cp2_q[1] <= sc_u1_2;
    for (int i = 2; i <= 4; i++) cp2_q[i] <= cp2_q[i-1];
  end
  assign log_e2  = m_log(lp2_q[2]);
  assign sqrt_f2 = use_fix ? fx_f  : m_sqrt(sp2_q);
  assign sc_g0_2 = use_fix ? fx_g0 : m_g0(cp2_q[4]);
  assign sc_g1_2 = use_fix ? fx_g1 : m_g1(cp2_q[4]);

  // Reference: signed product of Q4.13 magnitude and Q1.15 trig value, floored to Q5.11
  function automatic logic [15:0] smp(input logic [16:0] f, input logic [15:0] g);
    longint p;
    p = longint'(f) * longint'($signed(g));
    return 16'(p >>> 17);
  endfunction

  task automatic ref_pair(input logic [47:0] u0, input logic [15:0] u1,
                          output logic [15:0] s0, output logic [15:0] s1);
    logic [16:0] f;
    f  = m_sqrt(m_log((u0 == 48'd0) ? 48'd1 : u0));
    s0 = smp(f, m_g0(u1));
    s1 = smp(f, m_g1(u1));
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [47:0] u0;
    logic [15:0] u1;
    logic [16:0] f;
    logic [15:0] g0, g1;
    logic [47:0] lu;
    logic [15:0] s0, s1;
  } vec_t;
  vec_t vt [5];

  // One full pair on dut: accept, operand check, latency, optional OUT0 stall, both samples
  task automatic do_pair(input string nm, input logic [47:0] u0, input logic [15:0] u1,
                         input logic [47:0] exp_lu, input logic [15:0] e0, input logic [15:0] e1,
                         input int stall, input bit drop_en);
    int k;
    urng_u0 = u0; urng_u1 = u1; urng_valid = 1'b1; out_ready = (stall == 0);
    k = 0;
    while (!urng_ready && k < 20) begin @(negedge clk); k++; end
    chk({nm, "_accept"}, 64'(urng_ready), 64'd1);
    @(negedge clk);
    urng_valid = 1'b0;
    if (drop_en) en = 1'b0;
    chk({nm, "_log_u0"}, 64'(log_u0), 64'(exp_lu));
    chk({nm, "_sc_u1"}, 64'(sc_u1), 64'(u1));
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    chk({nm, "_latency"}, 64'(k), 64'd3);
    chk({nm, "_s0"}, 64'(out_data), 64'(e0));
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_hold_s0"}, 64'(out_data), 64'(e0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_valid1"}, 64'(out_valid), 64'd1);
    chk({nm, "_s1"}, 64'(out_data), 64'(e1));
    @(negedge clk);
    exp_pc = exp_pc + 16'd1;
    chk({nm, "_valid_off"}, 64'(out_valid), 64'd0);
    chk({nm, "_pair_cnt"}, 64'(pair_cnt), 64'(exp_pc));
    chk({nm, "_data_hold"}, 64'(out_data), 64'(e1));
    if (drop_en) begin
      chk({nm, "_idle_ready"}, 64'(urng_ready), 64'd0);
      urng_valid = 1'b1;
      @(negedge clk);
      chk({nm, "_idle_ready2"}, 64'(urng_ready), 64'd0);
      chk({nm, "_idle_valid"}, 64'(out_valid), 64'd0);
      urng_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s0, s1, q[$];
    int lat1, lat2, k;

    vt[0] = '{48'd27633567797105, 16'h1234, 17'h02000, 16'h4000, 16'hC000, 48'd27633567797105, 16'h0400, 16'hFC00};
    vt[1] = '{48'd0,              16'h0001, 17'h02000, 16'h7FFF, 16'h8000, 48'd1,              16'h07FF, 16'hF800};
    vt[2] = '{48'hFFFF_FFFF_FFFF, 16'hABCD, 17'h1FFFF, 16'h7FFF, 16'h8000, 48'hFFFF_FFFF_FFFF, 16'h7FFE, 16'h8000};
    vt[3] = '{48'd5,              16'h0000, 17'h00001, 16'hFFFF, 16'h0001, 48'd5,              16'hFFFF, 16'h0000};
    vt[4] = '{48'h8000_0000_0001, 16'h5555, 17'h10000, 16'h4000, 16'h2000, 48'h8000_0000_0001, 16'h2000, 16'h1000};

    rst_n = 1'b0; en = 1'b0; urng_valid = 1'b0; out_ready = 1'b0;
    urng_u0 = '0; urng_u1 = '0; use_fix = 1'b0; fx_f = '0; fx_g0 = '0; fx_g1 = '0;
    exp_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_urng_ready", 64'(urng_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_pair_cnt", 64'(pair_cnt), 64'd0);
    chk("rst_log_u0", 64'(log_u0), 64'd0);
    chk("rst_sqrt_e", 64'(sqrt_e), 64'd0);
    chk("rst_sc_u1", 64'(sc_u1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_ready", 64'(urng_ready), 64'd0);

    // Both instances accept the same pair on the same edge; compare first-valid latency
    en = 1'b1; urng_valid = 1'b1; out_ready = 1'b1;
    urng_u0 = 48'h1234_5678_9ABC; urng_u1 = 16'h2468;
    ref_pair(urng_u0, urng_u1, s0, s1);
    k = 0;
    while (!(urng_ready && urng_ready2) && k < 10) begin @(negedge clk); k++; end
    chk("lat_both_ready", 64'(urng_ready && urng_ready2), 64'd1);
    @(negedge clk);
    urng_valid = 1'b0;
    lat1 = -1; lat2 = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid && lat1 < 0) begin lat1 = c; chk("lat_d1_s0", 64'(out_data), 64'(s0)); end
      else if (out_valid && lat1 == c - 1) chk("lat_d1_s1", 64'(out_data), 64'(s1));
      if (out_valid2 && lat2 < 0) begin lat2 = c; chk("lat_d2_s0", 64'(out_data2), 64'(s0)); end
      else if (out_valid2 && lat2 == c - 1) chk("lat_d2_s1", 64'(out_data2), 64'(s1));
    end
    chk("lat_default", 64'(lat1), 64'd3);
    chk("lat_3_2", 64'(lat2), 64'd6);
    exp_pc = 16'd1;
    chk("lat_d1_pair_cnt", 64'(pair_cnt), 64'(exp_pc));
    chk("lat_d2_pair_cnt", 64'(pair_cnt2), 64'd1);

    use_fix = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fx_f = vt[i].f; fx_g0 = vt[i].g0; fx_g1 = vt[i].g1;
      do_pair($sformatf("vec%0d", i), vt[i].u0, vt[i].u1, vt[i].lu, vt[i].s0, vt[i].s1, 0, 1'b0);
    end

    fx_f = vt[0].f; fx_g0 = vt[0].g0; fx_g1 = vt[0].g1;
    do_pair("stall", vt[0].u0, vt[0].u1, vt[0].lu, vt[0].s0, vt[0].s1, 5, 1'b0);

    // Random handshakes on both sides, scored against the pair model
    use_fix = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      urng_valid = ($urandom_range(0, 3) != 0);
      urng_u0    = ($urandom_range(0, 15) == 0) ? 48'd0 : {16'($urandom), $urandom};
      urng_u1    = 16'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      if (urng_valid && urng_ready) begin
        ref_pair(urng_u0, urng_u1, s0, s1);
        q.push_back(s0); q.push_back(s1);
        exp_pc = exp_pc + 16'd1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_unexpected_sample", 64'(out_data), 64'hDEAD_0000);
        else chk("rand_sample", 64'(out_data), 64'(q.pop_front()));
      end
    end
    urng_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) chk("rand_drain_sample", 64'(out_data), 64'(q.pop_front()));
      k++;
    end
    chk("rand_drained", 64'(q.size()), 64'd0);
    @(negedge clk);
    chk("rand_pair_cnt", 64'(pair_cnt), 64'(exp_pc));

    // Reset pulse while the pair is in SQRT
    use_fix = 1'b1;
    fx_f = vt[0].f; fx_g0 = vt[0].g0; fx_g1 = vt[0].g1;
    urng_u0 = vt[1].u0; urng_u1 = vt[1].u1; urng_valid = 1'b1;
    k = 0;
    while (!urng_ready && k < 20) begin @(negedge clk); k++; end
    chk("rstmid_accept", 64'(urng_ready), 64'd1);
    @(negedge clk);
    urng_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_pair_cnt", 64'(pair_cnt), 64'd0);
    chk("rstmid_urng_ready", 64'(urng_ready), 64'd0);
    chk("rstmid_log_u0", 64'(log_u0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    @(negedge clk);
    chk("rstmid_no_residual", 64'(out_valid), 64'd0);
    do_pair("after_rst", vt[0].u0, vt[0].u1, vt[0].lu, vt[0].s0, vt[0].s1, 0, 1'b0);

    // Counter wrap from 16'hFFFF, with en dropped during LOG
    force dut.pair_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.pair_cnt_q;
    exp_pc = 16'hFFFF;
    @(negedge clk);
    chk("preset_pair_cnt", 64'(pair_cnt), 64'(exp_pc));
    fx_f = vt[2].f; fx_g0 = vt[2].g0; fx_g1 = vt[2].g1;
    do_pair("wrap_en_drop", vt[2].u0, vt[2].u1, vt[2].lu, vt[2].s0, vt[2].s1, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
